// File: rtl/seq_pkg.sv
// Shared state type and default sizes for the serial pattern transmitter.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PARITY,
        GAP,
        DONE
    } tx_state_t;

    localparam int PAT_W_DEF = 3;
    localparam int REP_W_DEF = 4;

endpackage

// File: rtl/seq_tx_shreg.sv
// MSB-first shift register: loads a new pattern, reloads the latched copy for
// the next word, and exposes the MSB it will hold after the coming edge.
module seq_tx_shreg #(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic             i_reload,
    input  logic             i_shift,
    output logic             o_next_msb
);

    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] r_sh;
    logic [PAT_W-1:0] w_sh_nxt;

    always_comb begin
        // NOTE: hold value assigned first so every path drives w_sh_nxt and no latch is inferred.
        w_sh_nxt = r_sh;
        if (i_load) begin
            w_sh_nxt = i_pattern;
        end else if (i_reload) begin
            w_sh_nxt = r_pat;
        end else if (i_shift) begin
            w_sh_nxt = r_sh << 1;
        end
    end

    // The top registers this bit directly, so the line is driven from a flop.
    assign o_next_msb = w_sh_nxt[PAT_W-1];

    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat <= '0;
            r_sh  <= '0;
        end else begin
            if (i_load) begin
                r_pat <= i_pattern;
            end
            r_sh <= w_sh_nxt;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first REPS times with
// GAP_CYC idle cycles between words. Define SEQ_TX_PARITY_EN for an even-parity bit per word.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W   = PAT_W_DEF,
    parameter int REP_W   = REP_W_DEF,
    parameter int GAP_CYC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    tx_state_t        w_end_state;
    logic [IDX_W-1:0] r_idx;
    logic [REP_W-1:0] r_rem;
    logic [GAP_W-1:0] r_gap;
    logic             r_out;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;
    logic             w_eow;
    logic             w_more;
    logic             w_shift;
    logic             w_reload;
    logic             w_next_msb;
    logic             w_out_nxt;
    logic             w_valid_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
`ifdef SEQ_TX_PARITY_EN
    logic             r_par;
`endif

    assign w_accept = (r_state == IDLE) && start;
`ifdef SEQ_TX_PARITY_EN
    assign w_eow    = (r_state == PARITY);
`else
    assign w_eow    = (r_state == SHIFT) && (r_idx == '0);
`endif
    assign w_more      = (r_rem > REP_W'(1));
    assign w_end_state = !w_more ? DONE : ((GAP_CYC > 0) ? GAP : SHIFT);
    assign w_shift     = (r_state == SHIFT) && (r_idx != '0);
    // Entering SHIFT for a later word (back-to-back or after a gap) restarts from the latched copy.
    assign w_reload    = (w_state_nxt == SHIFT) && !w_accept && !w_shift;

    seq_tx_shreg #(
        .PAT_W(PAT_W)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_pattern (pattern),
        .i_reload  (w_reload),
        .i_shift   (w_shift),
        .o_next_msb(w_next_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (start) w_state_nxt = (reps != '0) ? SHIFT : DONE;
`ifdef SEQ_TX_PARITY_EN
            SHIFT:  if (r_idx == '0) w_state_nxt = PARITY;
            PARITY: w_state_nxt = w_end_state;
`else
            SHIFT:  if (r_idx == '0) w_state_nxt = w_end_state;
`endif
            GAP:    if (r_gap == GAP_LAST) w_state_nxt = SHIFT;
            DONE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they appear one cycle after the decision.
    always_comb begin
        w_out_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            SHIFT: begin
                w_out_nxt   = w_next_msb;
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
`ifdef SEQ_TX_PARITY_EN
            PARITY: begin
                w_out_nxt   = r_par;
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
`endif
            GAP:     w_busy_nxt = 1'b1;
            DONE:    w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_rem       <= '0;
            r_gap       <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_shift) begin
                r_idx <= r_idx - 1'b1;
            end else if (w_state_nxt == SHIFT) begin
                r_idx <= IDX_TOP;
            end
            // The repeat count saturates at zero rather than wrapping.
            if (w_accept) begin
                r_rem <= reps;
            end else if (w_eow && (r_rem != '0)) begin
                r_rem <= r_rem - 1'b1;
            end
            r_gap       <= (r_state == GAP) ? r_gap + 1'b1 : '0;
            r_out       <= w_out_nxt;
            r_out_valid <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

`ifdef SEQ_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= ^pattern;
        end
    end
`endif

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (no gap, two-cycle gap) checked cycle by cycle
// against a word-level model of the transmitted sequence.
module tb_seq_pattern_tx;

    localparam int PAT_W = 3;
    localparam int REP_W = 4;
    localparam int GAP_A = 0;
    localparam int GAP_B = 2;
`ifdef SEQ_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       start;
    logic [PAT_W-1:0] pattern [2];
    logic [REP_W-1:0] reps [2];
    logic [1:0]       out;
    logic [1:0]       out_valid;
    logic [1:0]       busy;
    logic [1:0]       done;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle {busy, done, out_valid, out}, starting the cycle after the accepting edge.
    logic [3:0] exp_q[$];
    logic       stream[$];

    always #5 clk = ~clk;

    seq_pattern_tx #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_CYC(GAP_A)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .pattern(pattern[0]), .reps(reps[0]),
        .out(out[0]), .out_valid(out_valid[0]), .busy(busy[0]), .done(done[0])
    );

    seq_pattern_tx #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_CYC(GAP_B)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .pattern(pattern[1]), .reps(reps[1]),
        .out(out[1]), .out_valid(out_valid[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic build_model(input logic [PAT_W-1:0] pat, input int n_reps, input int gap);
        exp_q.delete();
        for (int r = 0; r < n_reps; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({3'b101, pat[b]});
            if (P != 0) exp_q.push_back({3'b101, ^pat});
            if (r < n_reps - 1)
                for (int g = 0; g < gap; g++) exp_q.push_back(4'b1000);
        end
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0000);
    endtask

    function automatic int count_101();
        int n = 0;
        for (int i = 0; i + 2 < stream.size(); i++)
            if (stream[i] && !stream[i+1] && stream[i+2]) n++;
        return n;
    endfunction

    task automatic run_and_check(input int d, input logic [PAT_W-1:0] pat,
                                 input logic [REP_W-1:0] nreps, input bit disturb, input string name);
        int gap;
        int done_at;
        int exp_done_at;
        logic [3:0] obs;
        gap = (d == 0) ? GAP_A : GAP_B;
        build_model(pat, int'(nreps), gap);
        stream.delete();
        done_at = -1;
        @(negedge clk);
        start[d]   = 1'b1;
        pattern[d] = pat;
        reps[d]    = nreps;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        foreach (exp_q[i]) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            obs = {busy[d], done[d], out_valid[d], out[d]};
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d: busy/done/valid/out got %b expected %b", name, i, obs, exp_q[i]);
            end
            if (out_valid[d]) stream.push_back(out[d]);
            if (done[d] && done_at < 0) done_at = i;
            if (disturb) begin
                // Start is dropped while busy or in DONE; it must be low in the final idle cycle.
                start[d]   = (i < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                pattern[d] = PAT_W'($urandom);
                reps[d]    = REP_W'($urandom);
            end
        end
        start[d] = 1'b0;
        exp_done_at = (nreps == 0) ? 0 : int'(nreps) * (PAT_W + P) + (int'(nreps) - 1) * gap;
        checks++;
        if (done_at !== exp_done_at) begin
            errors++;
            $display("FAIL %s done_offset: got %0d expected %0d", name, done_at, exp_done_at);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d], out_valid[d], out[d]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %b expected 0000", d,
                         {busy[d], done[d], out_valid[d], out[d]});
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_101();
        run_and_check(0, 3'b101, 4'd1, 1'b0, "single_101");
    endtask

    task automatic test_repeat_101();
        int exp_hits;
        run_and_check(0, 3'b101, 4'd3, 1'b0, "repeat_101");
        exp_hits = (P != 0) ? 5 : 3;
        checks++;
        if (count_101() !== exp_hits) begin
            errors++;
            $display("FAIL repeat_101 detector_hits: got %0d expected %0d", count_101(), exp_hits);
        end
    endtask

    task automatic test_zero_reps();
        for (int d = 0; d < 2; d++) begin
            run_and_check(d, 3'b111, 4'd0, 1'b0, "zero_reps");
            checks++;
            if (stream.size() !== 0) begin
                errors++;
                $display("FAIL zero_reps valid_bits dut%0d: got %0d expected 0", d, stream.size());
            end
        end
    endtask

    task automatic test_gap();
        run_and_check(1, 3'b110, 4'd2, 1'b0, "gap_110");
    endtask

    task automatic test_parity_word();
        run_and_check(0, 3'b101, 4'd2, 1'b0, "parity_word");
    endtask

    task automatic test_disturb();
        run_and_check(0, 3'b101, 4'd4, 1'b1, "disturb_dut0");
        run_and_check(1, 3'b011, 4'd3, 1'b1, "disturb_dut1");
    endtask

    task automatic test_max_reps();
        run_and_check(1, 3'b100, 4'd15, 1'b0, "max_reps");
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start[0]   = 1'b1;
        pattern[0] = 3'b101;
        reps[0]    = 4'd5;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy[0], out_valid[0], out[0]} !== 3'b110) begin
            errors++;
            $display("FAIL midrun_second_bit: got %b expected 110", {busy[0], out_valid[0], out[0]});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy[0], done[0], out_valid[0], out[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL midrun_reset_immediate: got %b expected 0000",
                     {busy[0], done[0], out_valid[0], out[0]});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy[0], done[0], out_valid[0], out[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL midrun_idle_after_release: got %b expected 0000",
                     {busy[0], done[0], out_valid[0], out[0]});
        end
        run_and_check(0, 3'b010, 4'd2, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_and_check(0, 3'b111, 4'd2, 1'b0, "b2b_a");
        run_and_check(0, 3'b001, 4'd1, 1'b0, "b2b_b");
        run_and_check(1, 3'b010, 4'd3, 1'b0, "b2b_c");
        run_and_check(1, 3'b000, 4'd1, 1'b0, "b2b_d");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            for (int d = 0; d < 2; d++) begin
                run_and_check(d, PAT_W'($urandom), REP_W'($urandom), 1'($urandom_range(0, 1)), "random");
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        start = '0;
        for (int d = 0; d < 2; d++) begin
            pattern[d] = '0;
            reps[d]    = '0;
        end
        test_reset();
        test_single_101();
        test_repeat_101();
        test_zero_reps();
        test_gap();
        test_parity_word();
        test_disturb();
        test_max_reps();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
